// File: rtl/controller_pkg.sv
// controller_pkg: opcode, mux-select, state and control-word definitions shared by the controller
package controller_pkg;
   localparam logic [3:0] NOP        = 4'b0000;
   localparam logic [3:0] ADD        = 4'b0001;
   localparam logic [3:0] SUB        = 4'b0010;
   localparam logic [3:0] NOR        = 4'b0011;
   localparam logic [3:0] REG_TO_ACC = 4'b0100;
   localparam logic [3:0] ACC_TO_REG = 4'b0101;
   localparam logic [3:0] JMPZ_REG   = 4'b0110;
   localparam logic [3:0] JMPZ_IMM   = 4'b0111;
   localparam logic [3:0] JMPNZ_REG  = 4'b1000;
   localparam logic [3:0] JMPC_IMM   = 4'b1001;
   localparam logic [3:0] JMPNZ_IMM  = 4'b1010;
   localparam logic [3:0] SHFL       = 4'b1011;
   localparam logic [3:0] SHFR       = 4'b1100;
   localparam logic [3:0] IMM_TO_ACC = 4'b1101;
   localparam logic [3:0] HALT       = 4'b1111;
   localparam logic [1:0] ACC_SRC_ALU = 2'b00;
   localparam logic [1:0] ACC_SRC_REG = 2'b01;
   localparam logic [1:0] ACC_SRC_IMM = 2'b10;
   localparam logic       PC_SRC_IMM  = 1'b0;
   localparam logic       PC_SRC_REG  = 1'b1;
   typedef enum logic [1:0] {S_RESET, S_FETCH, S_DECODE, S_EXECUTE} state_t;
   typedef struct packed {
      logic       selPc;
      logic       loadPc;
      logic       loadReg;
      logic       loadAcc;
      logic [1:0] selAcc;
      logic [3:0] selAlu;
   } ctrl_t;
endpackage

// File: rtl/controller_decode.sv
// controller_decode: combinational opcode/flag decode into the execute-phase control word
// Ports: opcode (4) instruction opcode, z zero flag, c carry flag (used only with CARRY_JUMP_EN),
//        ctrl execute-phase control word (selPc, loadPc, loadReg, loadAcc, selAcc, selAlu)
// Macro CARRY_JUMP_EN: decode 1001 as JMPC_IMM; otherwise 1001 is a NOP and c is ignored.
module controller_decode
   import controller_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       z,
   input  logic       c,
   output ctrl_t      ctrl
);
`ifndef CARRY_JUMP_EN
   logic unusedC;
   assign unusedC = c;
`endif
   // untaken jumps leave selPc at 0 so every output of a no-op is 0
   always_comb begin
      ctrl = '0;
      case (opcode)
         ADD, SUB, NOR, SHFR, SHFL: begin
            ctrl.loadAcc = 1'b1;
            ctrl.selAcc  = ACC_SRC_ALU;
            ctrl.selAlu  = opcode;
         end
         REG_TO_ACC: begin
            ctrl.loadAcc = 1'b1;
            ctrl.selAcc  = ACC_SRC_REG;
         end
         ACC_TO_REG: ctrl.loadReg = 1'b1;
         IMM_TO_ACC: begin
            ctrl.loadAcc = 1'b1;
            ctrl.selAcc  = ACC_SRC_IMM;
         end
         JMPZ_REG: begin
            ctrl.loadPc = z;
            ctrl.selPc  = z ? PC_SRC_REG : 1'b0;
         end
         JMPZ_IMM: ctrl.loadPc = z;
         JMPNZ_REG: begin
            ctrl.loadPc = !z;
            ctrl.selPc  = !z ? PC_SRC_REG : 1'b0;
         end
         JMPNZ_IMM: ctrl.loadPc = !z;
`ifdef CARRY_JUMP_EN
         JMPC_IMM: ctrl.loadPc = c;
`endif
         default: ;
      endcase
   end
endmodule

// File: rtl/controller_fsm.sv
// controller_fsm: fetch/decode/execute sequencer driving the accumulator CPU datapath strobes
// Ports: Clk clock, reset async active-low, Opcode (4) from IR, Z zero flag, C carry flag;
//        outputs LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc (2), SelALU (4)
// Macro CARRY_JUMP_EN: enables JMPC_IMM (opcode 1001) in the decoder.
module controller_fsm
   import controller_pkg::*;
(
   input  logic       Clk,
   input  logic       reset,
   input  logic [3:0] Opcode,
   input  logic       Z,
   input  logic       C,
   output logic       LoadIR,
   output logic       IncPC,
   output logic       SelPC,
   output logic       LoadPC,
   output logic       LoadReg,
   output logic       LoadAcc,
   output logic [1:0] SelAcc,
   output logic [3:0] SelALU
);
   state_t state, nextState;
   ctrl_t  execCtrl;
   controller_decode uDecode (
      .opcode(Opcode),
      .z     (Z),
      .c     (C),
      .ctrl  (execCtrl)
   );
   always_ff @(posedge Clk or negedge reset)
      if (!reset) state <= S_RESET;
      else        state <= nextState;
   // decoded word reaches the outputs only in S_EXECUTE, so Opcode/Z/C are ignored elsewhere
   always_comb begin
      nextState = state;
      LoadIR    = 1'b0;
      IncPC     = 1'b0;
      {SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU} = '0;
      case (state)
         S_RESET:  nextState = S_FETCH;
         S_FETCH: begin
            nextState = S_DECODE;
            LoadIR    = 1'b1;
            IncPC     = 1'b1;
         end
         S_DECODE: nextState = S_EXECUTE;
         S_EXECUTE: begin
            nextState = (Opcode == HALT) ? S_EXECUTE : S_FETCH;
            {SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU} = execCtrl;
         end
         default:  nextState = S_RESET;
      endcase
   end
endmodule

// File: tb/tb_controller_fsm.sv
// tb_controller_fsm: randomized scoreboard bench for controller_fsm against an instruction-level model
module tb_controller_fsm;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] opcode = 4'h1;
  logic z = 1'b0;
  logic c = 1'b0;
  logic load_ir, inc_pc, sel_pc, load_pc, load_reg, load_acc;
  logic [1:0] sel_acc;
  logic [3:0] sel_alu;
  logic [11:0] sb[$];
  logic [11:0] actual, exp_word;
  int compared = 0;
  int mismatched = 0;
  int cycle_no = 0;
  localparam logic [11:0] W_FETCH = 12'b110000_00_0000;
  localparam logic [11:0] W_IDLE = 12'h000;
  always #5 clk = ~clk;
  controller_fsm dut (
    .Clk(clk), .reset(reset), .Opcode(opcode), .Z(z), .C(c),
    .LoadIR(load_ir), .IncPC(inc_pc), .SelPC(sel_pc), .LoadPC(load_pc),
    .LoadReg(load_reg), .LoadAcc(load_acc), .SelAcc(sel_acc), .SelALU(sel_alu)
  );
  assign actual = {load_ir, inc_pc, sel_pc, load_pc, load_reg, load_acc, sel_acc, sel_alu};
  function automatic logic [11:0] exec_word(input logic [3:0] op, input logic zf, input logic cf);
    logic [11:0] w;
    logic taken, from_reg;
    w = 12'h000;
    taken = ((op == 4'h6 || op == 4'h7) && zf) || ((op == 4'h8 || op == 4'hA) && !zf);
`ifdef CARRY_JUMP_EN
    if (op == 4'h9) taken = cf;
`endif
    from_reg = (op == 4'h6 || op == 4'h8);
    if (op inside {4'h1, 4'h2, 4'h3, 4'hB, 4'hC}) w = {6'b000001, 2'b00, op};
    else if (op == 4'h4) w = 12'b000001_01_0000;
    else if (op == 4'h5) w = 12'b000010_00_0000;
    else if (op == 4'hD) w = 12'b000001_10_0000;
    else if (taken) w = {2'b00, from_reg, 1'b1, 8'h00};
    return w;
  endfunction
  always @(negedge clk) begin
    cycle_no++;
    if (sb.size() > 0) begin
      exp_word = sb.pop_front();
      compared++;
      if (actual !== exp_word) begin
        $display("FAIL ctrl_word cycle %0d: got %03h required %03h", cycle_no, actual, exp_word);
        mismatched++;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: wait expired at cycle %0d", cycle_no);
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  task automatic cyc(input logic r, input logic [3:0] op, input logic zf, input logic cf, input logic [11:0] w);
    @(posedge clk);
    #1;
    reset = r;
    opcode = op;
    z = zf;
    c = cf;
    sb.push_back(w);
  endtask
  task automatic instr(input logic [3:0] op, input logic zf, input logic cf, input int halt_extra,
                       input logic [3:0] exit_op);
    logic zz, cc;
    cyc(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), W_FETCH);
    cyc(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), W_IDLE);
    cyc(1'b1, op, zf, cf, exec_word(op, zf, cf));
    if (op == 4'hF) begin
      repeat (halt_extra) cyc(1'b1, 4'hF, 1'($urandom), 1'($urandom), W_IDLE);
      zz = 1'($urandom);
      cc = 1'($urandom);
      cyc(1'b1, exit_op, zz, cc, exec_word(exit_op, zz, cc));
    end
  endtask
  initial begin
    logic [3:0] op, exit_op;
    cyc(1'b0, 4'h1, 1'b0, 1'b0, W_IDLE);
    cyc(1'b0, 4'h1, 1'b0, 1'b0, W_IDLE);
    cyc(1'b1, 4'h1, 1'b0, 1'b0, W_IDLE);
    instr(4'h1, 1'b0, 1'b0, 0, 4'h0);
    instr(4'h1, 1'b1, 1'b0, 0, 4'h0);
    instr(4'h4, 1'b0, 1'b0, 0, 4'h0);
    instr(4'h5, 1'b0, 1'b0, 0, 4'h0);
    instr(4'hD, 1'b0, 1'b0, 0, 4'h0);
    instr(4'h6, 1'b1, 1'b0, 0, 4'h0);
    instr(4'h6, 1'b0, 1'b0, 0, 4'h0);
    instr(4'hA, 1'b0, 1'b0, 0, 4'h0);
    instr(4'hA, 1'b1, 1'b0, 0, 4'h0);
    instr(4'hF, 1'b0, 1'b0, 3, 4'h9);
    instr(4'h9, 1'b0, 1'b1, 0, 4'h0);
    instr(4'hE, 1'b1, 1'b1, 0, 4'h0);
    instr(4'h0, 1'b1, 1'b1, 0, 4'h0);
    cyc(1'b1, 4'($urandom), 1'b0, 1'b0, W_FETCH);
    cyc(1'b1, 4'($urandom), 1'b0, 1'b0, W_IDLE);
    @(posedge clk);
    #1;
    opcode = 4'h1;
    z = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    compared++;
    if (actual !== W_IDLE) begin
      $display("FAIL reset_state: got %03h required %03h immediately after reset", actual, W_IDLE);
      mismatched++;
    end
    sb.push_back(W_IDLE);
    cyc(1'b0, 4'h1, 1'b0, 1'b0, W_IDLE);
    cyc(1'b1, 4'h1, 1'b0, 1'b0, W_IDLE);
    instr(4'h2, 1'b0, 1'b0, 0, 4'h0);
    repeat (300) begin
      op = 4'($urandom);
      do exit_op = 4'($urandom); while (exit_op == 4'hF);
      instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, 3), exit_op);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
